// File: rtl/stream_demux_1to4_pkg.sv
// Shared constants and helpers for the 1-to-4 stream demultiplexer.
package stream_demux_1to4_pkg;

  // Lane count and the width of a lane index.
  localparam int LANES = 4;
  localparam int SEL_W = 2;

  // Values of rr_mode.
  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Bit offset of lane k inside a packed bus of n-bit lanes.
  function automatic int lane_slice(input int k, input int n);
    return k * n;
  endfunction

endpackage

// File: rtl/stream_demux_1to4_lane.sv
// One-entry lane register with a valid/ready output side.
// A write in the same cycle as a drain wins, so the lane refills
// with no bubble.
module demux_lane_reg #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [N-1:0] wr_data,
  input  logic         rd_ready,
  output logic [N-1:0] q,
  output logic         q_valid
);

  // Data register: loads on write, otherwise holds (not cleared on drain).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (wr_en) begin
      q <= wr_data;
    end
  end

  // Valid flag: set on write, cleared when the consumer takes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
    end else if (wr_en) begin
      q_valid <= 1'b1;
    end else if (q_valid && rd_ready) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream demultiplexer. Each input word is steered to
// one lane, chosen by in_sel or by a round-robin pointer.
// in_ready depends combinationally on out_ready (full-rate refill of a
// draining lane) but never on in_valid.
module stream_demux_1to4
  import stream_demux_1to4_pkg::*;
#(
  parameter int N     = 5,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               rr_mode,
  output logic [LANES*N-1:0] out_data,
  output logic [LANES-1:0]   out_valid,
  input  logic [LANES-1:0]   out_ready,
  output logic [SEL_W-1:0]   rr_ptr,
  output logic [CNT_W-1:0]   xfer_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SEL_W-1:0] tgt;
  logic             accept;
  logic [LANES-1:0] wr_en;

  // Target lane decode: pointer in round-robin mode, explicit select otherwise.
  always_comb begin
    tgt = (rr_mode == MODE_RR) ? rr_ptr : in_sel;
  end

  // Ready when the target lane is empty or being drained this cycle.
  always_comb begin
    in_ready = ~out_valid[tgt] | out_ready[tgt];
    accept   = in_valid & in_ready;
  end

  // One-hot write enable toward the target lane.
  always_comb begin
    wr_en = '0;
    if (accept) begin
      wr_en[tgt] = 1'b1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane_reg #(
      .N(N)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en[k]),
      .wr_data (in_data),
      .rd_ready(out_ready[k]),
      .q       (out_data[lane_slice(k, N) +: N]),
      .q_valid (out_valid[k])
    );
  end

  // Round-robin pointer: advances only on accepts made in round-robin mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept && (rr_mode == MODE_RR)) begin
      rr_ptr <= rr_ptr + SEL_W'(1);
    end
  end

  // Saturating count of accepted transfers in either mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_count <= '0;
    end else if (accept && (xfer_count != CNT_MAX)) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

endmodule
